instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the single-cycle core's decode/execute.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake, tolerating variable memory latency.
- Buffers fetched words in a small prefetch FIFO and hands {instr, pc} downstream with valid/ready.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

Parameters:
- WORD_LENGTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request; registered.
- imem_addr  output  WORD_LENGTH  fetch address, word aligned; registered.
- imem_ack  input  1  response strobe; imem_rdata valid this cycle.
- imem_rdata  input  WORD_LENGTH  fetched instruction word.
- redirect_valid  input  1  one-cycle pulse: resteer fetch.
- redirect_pc  input  WORD_LENGTH  new fetch PC.
- instr_valid  output  1  head of FIFO valid.
- instr  output  WORD_LENGTH  head instruction.
- instr_pc  output  WORD_LENGTH  PC of head instruction.
- instr_ready  input  1  downstream accepts head.

Behaviour:
- Reset (reset=0, async): imem_req=0, imem_addr=RESET_PC, FIFO count=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, state=ST_FETCH.
- Memory handshake:
  - At most one request outstanding.
  - imem_req may rise only when count<FIFO_DEPTH.
  - Once high, imem_req and imem_addr hold stable until the cycle imem_ack=1.
  - imem_ack while imem_req=0 is ignored.
- First request: imem_req=1 on the first rising edge after reset deasserts. Back-to-back fetch: imem_req stays high the cycle after ack if post-update count<FIFO_DEPTH.
- Accepted response (ack, state ST_FETCH, no redirect):
  - Push {imem_addr, imem_rdata}.
  - Next imem_addr = imem_addr+4, mod 2^WORD_LENGTH (wraps FFFF_FFFC→0).
- Downstream interface:
  - instr_valid = (count!=0).
  - instr and instr_pc driven from the FIFO head, combinational from FIFO storage.
  - Pop when instr_valid && instr_ready.
  - Simultaneous push+pop: count unchanged; data order preserved.
- FSM:
  - ST_FETCH: normal operation.
  - ST_DROP: a redirect arrived while a request was outstanding (imem_req=1, imem_ack=0). Hold the old request until ack, discard that data, then issue redirect target next edge; return to ST_FETCH.
- Redirect (redirect_valid=1):
  - A pop handshake in the same cycle completes first.
  - Then FIFO flushed (count=0, instr_valid=0 next cycle).
  - Target PC = {redirect_pc[WL-1:2], 2'b00}, stored in pending_pc.
  - If no request outstanding, or ack arrives the same cycle: discard any data; next cycle imem_req=1, imem_addr=target.
  - Otherwise go to ST_DROP.
  - A second redirect during ST_DROP overwrites pending_pc.
- Latency: ack at edge N → instr_valid=1 after edge N (visible cycle N+1) if FIFO was empty.
- Full FIFO: imem_req stays low until a pop; no data loss or overwrite is possible.
- Reset mid-request: all state cleared immediately; a late imem_ack after reset release with imem_req=0 is ignored.

Decomposition:
- Package ifu_pkg:
  - state enum {ST_FETCH, ST_DROP}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
  - FIFO entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO_DEPTH-entry FIFO.
  - Ports: push, pop, flush (flush dominates push), full, empty, count, head entry.
  - Same clk and active-low async reset.

Test Plan:
- Reset release, imem_ack one cycle after every req, instr_ready=1 → imem_addr sequence 0,4,8,C; instr_pc matches; one instr per cycle after fill.
- Memory returns words 0xA0..0xA3, instr_ready=0 → exactly 2 accepted, imem_req low, count=2. Then raise ready → 0xA0, 0xA1 in order, fetch resumes at 8.
- Redirect to 0x100 while req to 0x8 outstanding, ack 3 cycles later with 0xDEAD → 0xDEAD never appears. Next imem_addr=0x100; first instr_pc=0x100.
- Redirect to 0x203 coinciding with imem_ack and a pop → popped instr accepted, acked word dropped, FIFO empty, next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset (low) while imem_req=1 → imem_req=0, instr_valid=0 immediately (asynchronously, without waiting for a clock edge). A stray ack after release is ignored; first fetch is at RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifu_pkg;

  typedef enum logic {
    ST_FETCH,
    ST_DROP
  } ifu_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {pc, instr} pairs; head is read combinationally.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_pc,
  input  logic [W-1:0]  push_instr,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_pc,
  output logic [W-1:0]  head_instr
);

  logic [W-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_instr = instr_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is reset so the idle head presents a NOP at PC 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= W'(NOP_INSTR);
      end
    end else if (do_push && !flush) begin
      pc_mem[wr_ptr_reg]    <= push_pc;
      instr_mem[wr_ptr_reg] <= push_instr;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch sequencer: one outstanding imem request, prefetch FIFO, redirect with drop.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = '0,
  parameter int                     FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   instr_valid,
  output logic [WORD_LENGTH-1:0] instr,
  output logic [WORD_LENGTH-1:0] instr_pc,
  input  logic                   instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t             state_reg;
  logic                   req_reg;
  logic [WORD_LENGTH-1:0] addr_reg;
  logic [WORD_LENGTH-1:0] pending_pc_reg;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [CW-1:0]          count_next;
  logic                   room;
  logic [WORD_LENGTH-1:0] target;

  assign imem_req    = req_reg;
  assign imem_addr   = addr_reg;
  assign instr_valid = !fifo_empty;

  assign accept     = req_reg && imem_ack;
  assign pop        = instr_valid && instr_ready;
  assign push       = accept && (state_reg == ST_FETCH) && !redirect_valid && (!fifo_full || pop);
  assign count_next = fifo_count + CW'(push) - CW'(pop);
  assign room       = (count_next < CW'(FIFO_DEPTH));
  assign target     = redirect_pc & ~WORD_LENGTH'(3);

  fetch_fifo #(
    .W     (WORD_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (addr_reg),
    .push_instr (imem_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head_pc    (instr_pc),
    .head_instr (instr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_FETCH;
      req_reg        <= 1'b0;
      addr_reg       <= RESET_PC;
      pending_pc_reg <= RESET_PC;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (redirect_valid) begin
            pending_pc_reg <= target;
            if (!req_reg || imem_ack) begin
              req_reg  <= 1'b1;
              addr_reg <= target;
            end else begin
              state_reg <= ST_DROP;
            end
          end else begin
            if (accept) addr_reg <= addr_reg + WORD_LENGTH'(PC_STEP);
            // A live request must hold until acked; otherwise fetch whenever a slot will be free.
            if (!req_reg || imem_ack) req_reg <= room;
          end
        end
        ST_DROP: begin
          if (redirect_valid) pending_pc_reg <= target;
          if (imem_ack) begin
            req_reg   <= 1'b1;
            addr_reg  <= redirect_valid ? target : pending_pc_reg;
            state_reg <= ST_FETCH;
          end
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: vector table, directed redirect/reset sequences, randomized stream check.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  logic        imem_req2, imem_ack2, instr_valid2;
  logic [31:0] imem_addr2, imem_rdata2, instr2, instr_pc2;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2    = 32'h0;
  logic        instr_ready2    = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.WORD_LENGTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  // Second instance near the top of the address space; its memory acks every request at once.
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2;

  instr_fetch_unit #(.WORD_LENGTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2),
    .redirect_pc(redirect_pc2), .instr_valid(instr_valid2), .instr(instr2),
    .instr_pc(instr_pc2), .instr_ready(instr_ready2)
  );

  typedef struct {
    logic        rst;
    logic        chk2;
    logic        ack;
    logic        rdy;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        chk_head;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_addr2;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic r, input logic [31:0] d,
                       input logic rv, input logic [31:0] rp);
    imem_ack       = a;
    instr_ready    = r;
    imem_rdata     = d;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  // Leaves the bench at posedge+1 with reset just released and no edge seen since.
  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int          lat;
    int          pops;
    logic        rdy, ack, rv, prev_pend;
    logic [31:0] rp, exp_pc, prev_addr, rdata;

    // rst chk2 ack rdy rdata | req addr valid chk_head pc instr | addr2
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'h0, NOP_INSTR, 32'hFFFF_FFF8};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,  32'hFFFF_FFF8};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 32'h4,  1'b1, 1'b1, 32'h0, 32'h11, 32'hFFFF_FFFC};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 32'h8,  1'b1, 1'b1, 32'h4, 32'h22, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 32'hC,  1'b1, 1'b1, 32'h8, 32'h33, 32'h4};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'h10, 1'b1, 1'b1, 32'hC, 32'h44, 32'h8};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,  32'hC};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,  32'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA0, 1'b1, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,  32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b1, 32'h4,  1'b1, 1'b1, 32'h0, 32'hA0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b0, 32'h8,  1'b1, 1'b1, 32'h0, 32'hA0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA3, 1'b0, 32'h8,  1'b1, 1'b1, 32'h0, 32'hA0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h8,  1'b1, 1'b1, 32'h0, 32'hA0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'h8,  1'b1, 1'b1, 32'h4, 32'hA1, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1, 32'h8,  1'b0, 1'b0, 32'h0, 32'h0,  32'h0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  1'b1, 1'b1, 32'h8, 32'hA2, 32'h0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      chk($sformatf("tbl%0d req", i), imem_req, tbl[i].exp_req);
      chk($sformatf("tbl%0d addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d valid", i), instr_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid || tbl[i].chk_head) begin
        chk($sformatf("tbl%0d instr_pc", i), instr_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d instr", i), instr, tbl[i].exp_instr);
      end
      if (tbl[i].chk2) chk($sformatf("tbl%0d wrap_addr", i), imem_addr2, tbl[i].exp_addr2);
      $display("vec %0d req=%0b addr=%h valid=%0b pc=%h instr=%h", i, imem_req, imem_addr,
               instr_valid, instr_pc, instr);
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].rdata, 1'b0, 32'h0);
      tick();
    end

    // Redirect to 0x100 while the fetch of 0x8 is outstanding; stale 0xDEAD must vanish.
    do_reset();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);         tick();
    drive(1'b1, 1'b1, memfn(32'h0), 1'b0, 32'h0);  tick();
    drive(1'b1, 1'b1, memfn(32'h4), 1'b0, 32'h0);  tick();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);         tick();
    chk("drop pre req", imem_req, 1'b1);
    chk("drop pre addr", imem_addr, 32'h8);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);       tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("drop hold%0d addr", k), imem_addr, 32'h8);
      chk($sformatf("drop hold%0d valid", k), instr_valid, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0); tick();
    chk("drop new req", imem_req, 1'b1);
    chk("drop new addr", imem_addr, 32'h100);
    chk("drop no stale", instr_valid, 1'b0);
    drive(1'b1, 1'b1, memfn(32'h100), 1'b0, 32'h0); tick();
    chk("drop first pc", instr_pc, 32'h100);
    chk("drop first instr", instr, memfn(32'h100));
    $display("seq drop: addr=%h pc=%h instr=%h", imem_addr, instr_pc, instr);

    // Redirect to 0x203 together with an ack and a pop.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         tick();
    drive(1'b1, 1'b0, memfn(32'h0), 1'b0, 32'h0);  tick();
    chk("coinc pop valid", instr_valid, 1'b1);
    chk("coinc pop pc", instr_pc, 32'h0);
    chk("coinc req", imem_req, 1'b1);
    drive(1'b1, 1'b1, memfn(32'h4), 1'b1, 32'h203); tick();
    chk("coinc flushed", instr_valid, 1'b0);
    chk("coinc addr", imem_addr, 32'h200);
    chk("coinc req after", imem_req, 1'b1);
    drive(1'b1, 1'b1, memfn(32'h200), 1'b0, 32'h0); tick();
    chk("coinc first pc", instr_pc, 32'h200);
    chk("coinc first valid", instr_valid, 1'b1);
    $display("seq coinc: addr=%h pc=%h valid=%0b", imem_addr, instr_pc, instr_valid);

    // Asynchronous reset while a request is outstanding, then a stray ack.
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);         tick();
    drive(1'b1, 1'b0, memfn(32'h0), 1'b0, 32'h0);  tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("arst pre req", imem_req, 1'b1);
    chk("arst pre valid", instr_valid, 1'b1);
    #3 reset = 1'b0;
    #1;
    chk("arst req", imem_req, 1'b0);
    chk("arst valid", instr_valid, 1'b0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst instr", instr, NOP_INSTR);
    drive(1'b1, 1'b0, 32'h0000_DEAD, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("arst stray req", imem_req, 1'b1);
    chk("arst stray addr", imem_addr, 32'h0);
    chk("arst stray valid", instr_valid, 1'b0);
    $display("seq arst: req=%0b addr=%h valid=%0b", imem_req, imem_addr, instr_valid);

    // Randomized run: the popped stream must be consecutive words from the last redirect target.
    do_reset();
    exp_pc    = 32'h0;
    lat       = $urandom_range(0, 3);
    pops      = 0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      if (prev_pend) begin
        chk($sformatf("rnd%0d hold req", c), imem_req, 1'b1);
        chk($sformatf("rnd%0d hold addr", c), imem_addr, prev_addr);
      end
      if (imem_req) begin
        if (lat == 0) begin
          ack   = 1'b1;
          rdata = memfn(imem_addr);
          lat   = $urandom_range(0, 3);
        end else begin
          ack   = 1'b0;
          rdata = 32'h0000_DEAD;
          lat--;
        end
      end else begin
        ack   = ($urandom_range(0, 4) == 0);
        rdata = 32'h0000_DEAD;
      end
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rp  = $urandom_range(0, 32'h3FFF);
      if (instr_valid && rdy) begin
        chk($sformatf("rnd%0d pc", c), instr_pc, exp_pc);
        chk($sformatf("rnd%0d instr", c), instr, memfn(exp_pc));
        $display("rnd pop %0d pc=%h instr=%h", c, instr_pc, instr);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (rv) exp_pc = rp & 32'hFFFF_FFFC;
      prev_pend = imem_req && !ack;
      prev_addr = imem_addr;
      drive(ack, rdy, rdata, rv, rp);
      tick();
    end
    chk("rnd progress", 32'(pops > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
